// File: rtl/rv_pipe_pkg.sv
// rv_pipe_pkg: shared pipeline types and constants
package rv_pipe_pkg;
   typedef enum logic [1:0] {RUN, MEM_WAIT, MD_WAIT} state_t;
   localparam logic [4:0] REG_X0 = 5'd0;
endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// hazard_detect: load-use hazard compare between the load in EX and the ID source operands
module hazard_detect
   import rv_pipe_pkg::*;
(
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   input  logic       id_rs1_used,
   input  logic       id_rs2_used,
   input  logic [4:0] ex_rd,
   input  logic       ex_mem_read,
   output logic       lu
);
   assign lu = ex_mem_read && ex_rd != REG_X0 &&
               ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline with stall counter and memory timeout
module pipeline_hazard_ctrl
   import rv_pipe_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_rs1_used,
   input  logic             id_rs2_used,
   input  logic [4:0]       ex_rd,
   input  logic             ex_mem_read,
   input  logic             ex_redirect,
   input  logic             ex_md_start,
   input  logic             md_done,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             pc_stop,
   output logic             if_id_stop,
   output logic             if_id_flush,
   output logic             id_ex_stop,
   output logic             id_ex_flush,
   output logic             ex_mem_stop,
   output logic             ex_mem_flush,
   output logic             mem_wb_flush,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cnt
);
   localparam int WW = $clog2(MEM_TIMEOUT);
   state_t          state;
   logic [WW-1:0]   wcnt;
   logic            tmo, memwait, mdwait, lu, m, d, r, l;
   hazard_detect u_hd (
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .id_rs1_used (id_rs1_used),
      .id_rs2_used (id_rs2_used),
      .ex_rd       (ex_rd),
      .ex_mem_read (ex_mem_read),
      .lu          (lu)
   );
   assign tmo     = state == MEM_WAIT && wcnt == WW'(MEM_TIMEOUT - 1);
   assign memwait = mem_req && !mem_ready && !tmo;
   assign mdwait  = ex_md_start && !md_done;
   // one-hot priority rows so no register ever sees stop and flush together
   assign m = memwait;
   assign d = !m && mdwait;
   assign r = !m && !d && ex_redirect;
   assign l = !m && !d && !r && lu;
   assign pc_stop      = m || d || l;
   assign if_id_stop   = m || d || l;
   assign if_id_flush  = r;
   assign id_ex_stop   = m || d;
   assign id_ex_flush  = r || l;
   assign ex_mem_stop  = m;
   assign ex_mem_flush = d;
   assign mem_wb_flush = m;
   assign mem_err      = tmo;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= RUN;
         wcnt      <= '0;
         stall_cnt <= '0;
      end else begin
         state <= memwait ? MEM_WAIT : mdwait ? MD_WAIT : RUN;
         wcnt  <= memwait ? (state == MEM_WAIT ? wcnt + 1'b1 : WW'(1)) : '0;
         if (pc_stop && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
      end
   end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed self-checking bench for the stall/flush sequencer
module tb_pipeline_hazard_ctrl;
   import rv_pipe_pkg::*;
   logic        clk, rst_n;
   logic [4:0]  id_rs1, id_rs2, ex_rd;
   logic        id_rs1_used, id_rs2_used, ex_mem_read, ex_redirect, ex_md_start, md_done, mem_req, mem_ready;
   logic        pc_stop, if_id_stop, if_id_flush, id_ex_stop, id_ex_flush;
   logic        ex_mem_stop, ex_mem_flush, mem_wb_flush, mem_err;
   logic [31:0] stall_cnt;
   logic [8:0]  ctl;
   int          checks, errors;
   // {pc_stop, if_id_stop, if_id_flush, id_ex_stop, id_ex_flush, ex_mem_stop, ex_mem_flush, mem_wb_flush, mem_err}
   localparam logic [8:0] IDLE = 9'b000000000;
   localparam logic [8:0] MEMW = 9'b110101010;
   localparam logic [8:0] MDW  = 9'b110100100;
   localparam logic [8:0] RED  = 9'b001010000;
   localparam logic [8:0] LUS  = 9'b110010000;
   localparam logic [8:0] TMO  = 9'b000000001;
   pipeline_hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect),
      .ex_md_start(ex_md_start), .md_done(md_done), .mem_req(mem_req), .mem_ready(mem_ready),
      .pc_stop(pc_stop), .if_id_stop(if_id_stop), .if_id_flush(if_id_flush),
      .id_ex_stop(id_ex_stop), .id_ex_flush(id_ex_flush), .ex_mem_stop(ex_mem_stop),
      .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush), .mem_err(mem_err),
      .stall_cnt(stall_cnt)
   );
   assign ctl = {pc_stop, if_id_stop, if_id_flush, id_ex_stop, id_ex_flush,
                 ex_mem_stop, ex_mem_flush, mem_wb_flush, mem_err};
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic clr();
      {id_rs1, id_rs2, ex_rd} = '0;
      {id_rs1_used, id_rs2_used, ex_mem_read, ex_redirect, ex_md_start, md_done, mem_req, mem_ready} = '0;
   endtask
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask
   task automatic test_reset();
      rst_n = 1'b0;
      clr();
      #12;
      checks++;
      if (ctl !== IDLE) begin errors++; $display("FAIL reset_ctl got %b want %b", ctl, IDLE); end
      checks++;
      if (stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", stall_cnt); end
      checks++;
      if (dut.state !== RUN) begin errors++; $display("FAIL reset_state got %0d want RUN", dut.state); end
      rst_n = 1'b1;
   endtask
   task automatic test_load_use();
      cyc();
      ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_rs1_used = 1;
      #1;
      checks++;
      if (ctl !== LUS) begin errors++; $display("FAIL lu_stall got %b want %b", ctl, LUS); end
      cyc();
      clr();
      #1;
      checks++;
      if (ctl !== IDLE) begin errors++; $display("FAIL lu_release got %b want %b", ctl, IDLE); end
      checks++;
      if (stall_cnt !== 32'd1) begin errors++; $display("FAIL lu_cnt got %0d want 1", stall_cnt); end
   endtask
   task automatic test_x0_and_rs2();
      cyc();
      ex_mem_read = 1; ex_rd = 0; id_rs1 = 0; id_rs1_used = 1; id_rs2 = 0; id_rs2_used = 1;
      #1;
      checks++;
      if (ctl !== IDLE) begin errors++; $display("FAIL x0_load got %b want %b", ctl, IDLE); end
      cyc();
      ex_rd = 9; id_rs1 = 9; id_rs1_used = 0; id_rs2 = 3; id_rs2_used = 1;
      #1;
      checks++;
      if (ctl !== IDLE) begin errors++; $display("FAIL rs1_unused got %b want %b", ctl, IDLE); end
      cyc();
      ex_rd = 7; id_rs2 = 7;
      #1;
      checks++;
      if (ctl !== LUS) begin errors++; $display("FAIL rs2_lu got %b want %b", ctl, LUS); end
      cyc();
      clr();
      #1;
      checks++;
      if (stall_cnt !== 32'd2) begin errors++; $display("FAIL x0_cnt got %0d want 2", stall_cnt); end
   endtask
   task automatic test_mem_wait();
      for (int i = 0; i < 3; i++) begin
         cyc();
         mem_req = 1; mem_ready = 0;
         #1;
         checks++;
         if (ctl !== MEMW) begin errors++; $display("FAIL memwait_%0d got %b want %b", i, ctl, MEMW); end
      end
      checks++;
      if (dut.state !== MEM_WAIT) begin errors++; $display("FAIL memwait_state got %0d want MEM_WAIT", dut.state); end
      cyc();
      mem_ready = 1;
      #1;
      checks++;
      if (ctl !== IDLE) begin errors++; $display("FAIL mem_release got %b want %b", ctl, IDLE); end
      cyc();
      clr();
      #1;
      checks++;
      if (dut.state !== RUN) begin errors++; $display("FAIL mem_run got %0d want RUN", dut.state); end
      checks++;
      if (stall_cnt !== 32'd5) begin errors++; $display("FAIL mem_cnt got %0d want 5", stall_cnt); end
      mem_req = 1; mem_ready = 1;
      #1;
      checks++;
      if (ctl !== IDLE) begin errors++; $display("FAIL same_cycle_hs got %b want %b", ctl, IDLE); end
      cyc();
      clr();
      #1;
      checks++;
      if (dut.state !== RUN || stall_cnt !== 32'd5) begin
         errors++; $display("FAIL hs_after got state %0d cnt %0d want RUN 5", dut.state, stall_cnt);
      end
   endtask
   task automatic test_timeout();
      for (int k = 1; k <= 16; k++) begin
         cyc();
         mem_req = 1; mem_ready = 0;
         #1;
         checks++;
         if (ctl !== (k < 16 ? MEMW : TMO)) begin
            errors++; $display("FAIL tmo_cycle_%0d got %b want %b", k, ctl, (k < 16 ? MEMW : TMO));
         end
      end
      cyc();
      clr();
      #1;
      checks++;
      if (dut.state !== RUN) begin errors++; $display("FAIL tmo_state got %0d want RUN", dut.state); end
      checks++;
      if (ctl !== IDLE) begin errors++; $display("FAIL tmo_after got %b want %b", ctl, IDLE); end
      checks++;
      if (stall_cnt !== 32'd20) begin errors++; $display("FAIL tmo_cnt got %0d want 20", stall_cnt); end
   endtask
   task automatic test_md_redirect();
      for (int i = 0; i < 4; i++) begin
         cyc();
         ex_md_start = 1; ex_redirect = 1; md_done = 0;
         #1;
         checks++;
         if (ctl !== MDW) begin errors++; $display("FAIL mdwait_%0d got %b want %b", i, ctl, MDW); end
      end
      checks++;
      if (dut.state !== MD_WAIT) begin errors++; $display("FAIL md_state got %0d want MD_WAIT", dut.state); end
      cyc();
      md_done = 1;
      #1;
      checks++;
      if (ctl !== RED) begin errors++; $display("FAIL md_done_redirect got %b want %b", ctl, RED); end
      cyc();
      clr();
      #1;
      checks++;
      if (dut.state !== RUN || stall_cnt !== 32'd24) begin
         errors++; $display("FAIL md_after got state %0d cnt %0d want RUN 24", dut.state, stall_cnt);
      end
   endtask
   task automatic test_priority();
      cyc();
      mem_req = 1; ex_md_start = 1; ex_redirect = 1; ex_mem_read = 1; ex_rd = 4; id_rs1 = 4; id_rs1_used = 1;
      #1;
      checks++;
      if (ctl !== MEMW) begin errors++; $display("FAIL prio_mem got %b want %b", ctl, MEMW); end
      mem_req = 0;
      #1;
      checks++;
      if (ctl !== MDW) begin errors++; $display("FAIL prio_md got %b want %b", ctl, MDW); end
      ex_md_start = 0;
      #1;
      checks++;
      if (ctl !== RED) begin errors++; $display("FAIL prio_red got %b want %b", ctl, RED); end
      mem_req = 1;
      cyc();
      clr();
      #1;
      checks++;
      if (stall_cnt !== 32'd25) begin errors++; $display("FAIL prio_cnt got %0d want 25", stall_cnt); end
   endtask
   task automatic test_reset_mid_wait();
      for (int i = 0; i < 2; i++) begin
         cyc();
         mem_req = 1; mem_ready = 0;
      end
      #1;
      checks++;
      if (dut.state !== MEM_WAIT) begin errors++; $display("FAIL pre_rst_state got %0d want MEM_WAIT", dut.state); end
      rst_n = 0;
      clr();
      #1;
      checks++;
      if (ctl !== IDLE) begin errors++; $display("FAIL rst_mid_ctl got %b want %b", ctl, IDLE); end
      checks++;
      if (stall_cnt !== 32'd0) begin errors++; $display("FAIL rst_mid_cnt got %0d want 0", stall_cnt); end
      checks++;
      if (dut.state !== RUN) begin errors++; $display("FAIL rst_mid_state got %0d want RUN", dut.state); end
      cyc();
      rst_n = 1;
      cyc();
      checks++;
      if (ctl !== IDLE || stall_cnt !== 32'd0) begin
         errors++; $display("FAIL post_rst got %b cnt %0d want %b 0", ctl, stall_cnt, IDLE);
      end
   endtask
   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_load_use();
      test_x0_and_rs2();
      test_mem_wait();
      test_timeout();
      test_md_redirect();
      test_priority();
      test_reset_mid_wait();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
